sseg_display_arbiter: RTL

- Shares the 8-digit seven-segment display between the always-present clock readout and two one-shot message requesters, A and B. Examples of messages are "SET" prompts and alarm banners.
- Drives the eight 6-bit digit fields consumed by the display scan driver. Each field is {en, code[3:0], dp}.
- In idle it shows base digits, with per-digit blinking for time-setting.
- A granted message is frozen on the display for a fixed number of tick pulses, then control returns to the base digits.

---
 rtl/sseg_display_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sseg_display_arbiter.sv
// Shares the 8-digit seven-segment display between blinking base digits and
// two one-shot message requesters (A/B) with round-robin tie-breaking.
module sseg_display_arbiter #(
   parameter int HOLD_TICKS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic [47:0] base_digits,
   input  logic [7:0]  blink_mask,
   input  logic        req_a,
   input  logic [47:0] msg_a,
   input  logic        req_b,
   input  logic [47:0] msg_b,
   input  logic        cancel,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic        busy,
   output logic [5:0]  l0,
   output logic [5:0]  l1,
   output logic [5:0]  l2,
   output logic [5:0]  l3,
   output logic [5:0]  l4,
   output logic [5:0]  l5,
   output logic [5:0]  l6,
   output logic [5:0]  l7
);

   localparam int HOLD_EFF = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
   localparam int CW = $clog2(HOLD_EFF + 1);
   localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_EFF);

   typedef enum logic [1:0] {IDLE, SHOW_A, SHOW_B} state_t;

   state_t        state_q, state_d;
   logic          phase_q, phase_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_b_q, last_b_d;
   logic          holdoff_q, holdoff_d;
   logic          busy_q, busy_d;
   logic [47:0]   msg_q, msg_d;
   logic [47:0]   l_q, l_d;
   logic [47:0]   base_view;
   logic          win_a, win_b;

   always_comb begin
      base_view = base_digits;
      for (int k = 0; k < 8; k++)
         if (phase_q && blink_mask[k]) base_view[6*k+5] = 1'b0;
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      cnt_d     = cnt_q;
      last_b_d  = last_b_q;
      holdoff_d = 1'b0;
      msg_d     = msg_q;
      l_d       = base_view;
      win_a     = 1'b0;
      win_b     = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick) phase_d = ~phase_q;
            // First IDLE cycle after a message always shows base digits.
            if (!holdoff_q) begin
               if (req_a && (!req_b || last_b_q)) win_a = 1'b1;
               else if (req_b)                    win_b = 1'b1;
            end
            if (win_a) begin
               state_d  = SHOW_A;
               msg_d    = msg_a;
               l_d      = msg_a;
               last_b_d = 1'b0;
               cnt_d    = '0;
            end else if (win_b) begin
               state_d  = SHOW_B;
               msg_d    = msg_b;
               l_d      = msg_b;
               last_b_d = 1'b1;
               cnt_d    = '0;
            end
         end
         SHOW_A, SHOW_B: begin
            l_d = msg_q;
            if (cancel || (tick && (cnt_q >= HOLD_LIM - 1'b1))) begin
               state_d   = IDLE;
               cnt_d     = '0;
               phase_d   = 1'b0;
               holdoff_d = 1'b1;
            end else if (tick) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         phase_q   <= 1'b0;
         cnt_q     <= '0;
         last_b_q  <= 1'b1;
         holdoff_q <= 1'b0;
         busy_q    <= 1'b0;
         msg_q     <= '0;
         l_q       <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         cnt_q     <= cnt_d;
         last_b_q  <= last_b_d;
         holdoff_q <= holdoff_d;
         busy_q    <= busy_d;
         msg_q     <= msg_d;
         l_q       <= l_d;
      end
   end

   // Grants are Mealy pulses in the deciding cycle; masked while in reset.
   assign gnt_a = win_a & reset;
   assign gnt_b = win_b & reset;
   assign busy  = busy_q;
   assign l0 = l_q[5:0];
   assign l1 = l_q[11:6];
   assign l2 = l_q[17:12];
   assign l3 = l_q[23:18];
   assign l4 = l_q[29:24];
   assign l5 = l_q[35:30];
   assign l6 = l_q[41:36];
   assign l7 = l_q[47:42];

endmodule
